sram_1r1w_ctrl: RTL and testbench
=================================

// Module: sram_1r1w_ctrl
// PURPOSE
//  Front-end controller between a client pipeline stage and a sram_1r1w_<W>x<D> macro wrapper.
//  After reset or a clear request, sweeps every entry to INIT_VALUE.
//  Then forwards client reads and writes, with read-during-write bypass so the result is always NEW_DATA.
//  Holds read_data stable between reads.
// PARAMETERS
//  DATA_WIDTH   32               client data width in bits
//  SIZE         64               number of entries; need not be a power of two
//  ADDR_WIDTH   $clog2(SIZE)     address width
//  INIT_VALUE   {DATA_WIDTH{1'b0}}  value written to every entry during init
// PORTS
//  clk             in   1             clock, rising edge
//  reset_n         in   1             asynchronous reset, active low
//  clear           in   1             1-cycle pulse: restart init sweep
//  init_done       out  1             1 = sweep complete, client ports live
//  read_en         in   1             client read request
//  read_addr       in   ADDR_WIDTH    client read address
//  read_data       out  DATA_WIDTH    read result, valid 1 cycle after read_en
//  write_en        in   1             client write request
//  write_addr      in   ADDR_WIDTH    client write address
//  write_data      in   DATA_WIDTH    client write data
//  mem_read_en     out  1             to macro wrapper read_en
//  mem_read_addr   out  ADDR_WIDTH    to macro wrapper read_addr
//  mem_read_data   in   MW            from macro wrapper read_data (sync read, 1 cycle)
//  mem_write_en    out  1             to macro wrapper write_en
//  mem_write_addr  out  ADDR_WIDTH    to macro wrapper write_addr
//  mem_write_data  out  MW            to macro wrapper write_data
//  parity_error    out  1             1-cycle pulse on parity mismatch (see CONFIGURATION)
//  MW = DATA_WIDTH, or DATA_WIDTH+1 with SRAM_CTRL_PARITY_EN
// BEHAVIOUR
//  Reset values (reset_n low):
//   state=INIT, init_cnt=0, init_done=0, read_data=0, parity_error=0, all internal valid/bypass flags=0.
//  FSM INIT:
//   - Each cycle: mem_write_en=1, mem_write_addr=init_cnt, mem_write_data=INIT_VALUE; init_cnt++.
//   - At init_cnt==SIZE-1, go to RUN on the next edge.
//   - The sweep lasts exactly SIZE cycles; init_cnt never exceeds SIZE-1.
//  FSM RUN:
//   - init_done=1.
//   - mem_write_* = write_*, and mem_read_* = read_*, combinationally.
//  clear in either state:
//   - Next state INIT with init_cnt=0 and init_done=0 from the next cycle.
//   - A clear during INIT restarts the sweep at 0.
//   - reset_n asserted mid-sweep behaves the same way.
//  Client requests while init_done=0:
//   - Writes are dropped.
//   - Reads do not reach the macro; the next-cycle read_data is INIT_VALUE.
//  Read latency: exactly 1 cycle. rd_valid_q <= read_en.
//   - rd_valid_q=1: read_data = bypass_q ? byp_data_q : mem_read_data.
//   - rd_valid_q=0: read_data = hold_q (last presented value).
//   - hold_q <= read_data every cycle.
//  Bypass:
//   - Set when read_en & write_en & read_addr==write_addr in RUN.
//   - bypass_q<=1 and byp_data_q<=write_data; the next cycle returns write_data regardless of the macro.
//   - Different addresses: no bypass.
//   - A write one cycle after a read to the same address does not affect that read's data (old data).
//  Back-to-back reads: one result per cycle, no bubbles.
// CONFIGURATION
//  SRAM_CTRL_PARITY_EN defined:
//   - MW=DATA_WIDTH+1; stored bit MW-1 = ^data, for init writes too.
//   - On a non-bypassed valid read, parity_error pulses 1 for that cycle if ^mem_read_data != 0 (even total).
//   - Data is still returned.
//  Not defined:
//   - MW=DATA_WIDTH, no parity logic; parity_error tied 0.
// TESTING
//  1. SIZE=52:
//     - release reset_n -> init_done rises after exactly 52 cycles.
//     - mem_write_addr covers 0..51 once; no write to 52..63.
//  2. After init:
//     - write 0xDEADBEEF @5, then read @5 next cycle -> read_data=0xDEADBEEF one cycle after read_en.
//     - read @6 -> INIT_VALUE.
//  3. Same-cycle read+write @9:
//     - @9 holds 0x11; write 0x22 -> read_data=0x22.
//     - Read @9 and write @10 together -> 0x11.
//  4. Pulse clear mid-RUN, then client write 0x33 @3 during init:
//     - init_done drops; after SIZE cycles a read @3 returns INIT_VALUE.
//     - Repeat with reset_n asserted mid-sweep.
//  5. Read 0x44 then idle 5 cycles -> read_data stays 0x44; back-to-back reads return in order.
//  6. With SRAM_CTRL_PARITY_EN:
//     - force one flipped bit in mem_read_data -> parity_error=1 for one cycle.
//     - Bypassed read with corrupted macro data -> parity_error=0.

Source files
------------

// File: rtl/sram_1r1w_ctrl.sv
// sram_1r1w_ctrl: front-end controller for a 1-read/1-write synchronous SRAM macro wrapper.
//
// After reset or a clear pulse the controller sweeps every entry to INIT_VALUE, one entry per
// cycle. It then forwards client reads and writes straight to the macro. When a read and a write
// hit the same address in the same cycle, the read returns the new write data. read_data holds
// its last value between reads.
//
// Optional feature macro: SRAM_CTRL_PARITY_EN
//   When defined, every stored word carries an even-parity bit in its MSB, including init
//   writes. A non-bypassed read whose word fails the check pulses parity_error for that cycle.
//   The data is still returned. When the macro is undefined, parity_error is tied low.
//
// Ports
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   clear                    1-cycle pulse that restarts the init sweep
//   init_done                high once the sweep has finished and the client ports are live
//   read_en/addr, read_data  client read port; data is valid one cycle after read_en
//   write_en/addr/data       client write port
//   mem_read_*               to/from the macro read port (synchronous read, 1-cycle latency)
//   mem_write_*              to the macro write port
//   parity_error             1-cycle pulse on a parity mismatch (parity build only)

module sram_1r1w_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE       = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(SIZE),
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
`ifdef SRAM_CTRL_PARITY_EN
  localparam int unsigned MemWidth = DATA_WIDTH + 1
`else
  localparam int unsigned MemWidth = DATA_WIDTH
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  output logic                  init_done,

  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,

  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,

  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [MemWidth-1:0]   mem_read_data,

  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [MemWidth-1:0]   mem_write_data,

  output logic                  parity_error
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_done_q;

  logic                  rd_valid_q;
  logic                  bypass_q;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic [DATA_WIDTH-1:0] hold_q;

  logic                  run;
  logic                  same_addr;

  // Attach the stored-word check bit (if any) to a data word.
  function automatic logic [MemWidth-1:0] encode(input logic [DATA_WIDTH-1:0] d);
`ifdef SRAM_CTRL_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  assign run       = (state_q == StRun);
  assign same_addr = (read_addr == write_addr);
  assign init_done = init_done_q;

  // --------------------------------------------------------------------------------------------
  // Init / run FSM. init_done is registered alongside the state so it rises on the same edge
  // the sweep's last write completes.
  // --------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else if (clear) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (init_cnt_q == LastAddr) begin
            // Counter parks at the last entry; it is zeroed again on the next clear/reset.
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        StRun: begin
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= StInit;
          init_cnt_q  <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------------------------
  // Macro port steering: the sweep owns the write port during init, and client reads are
  // blocked from reaching the macro.
  // --------------------------------------------------------------------------------------------
  always_comb begin
    mem_write_en   = 1'b1;
    mem_write_addr = init_cnt_q;
    mem_write_data = encode(INIT_VALUE);
    mem_read_en    = 1'b0;
    mem_read_addr  = read_addr;
    if (run) begin
      mem_write_en   = write_en;
      mem_write_addr = write_addr;
      mem_write_data = encode(write_data);
      mem_read_en    = read_en;
    end
  end

  // --------------------------------------------------------------------------------------------
  // Read pipeline. A bypass captures the word the read must return instead of the macro output:
  // the same-cycle write data in run, or INIT_VALUE for a read issued before init completes.
  // --------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      bypass_q   <= 1'b0;
      byp_data_q <= '0;
      hold_q     <= '0;
    end else begin
      rd_valid_q <= read_en;
      bypass_q   <= read_en & (~run | (write_en & same_addr));
      if (read_en) begin
        byp_data_q <= run ? write_data : INIT_VALUE;
      end
      hold_q <= read_data;
    end
  end

  always_comb begin
    read_data = hold_q;
    if (rd_valid_q) begin
      read_data = bypass_q ? byp_data_q : mem_read_data[DATA_WIDTH-1:0];
    end
  end

`ifdef SRAM_CTRL_PARITY_EN
  // Even parity over data plus check bit; only meaningful when the macro supplied the data.
  assign parity_error = rd_valid_q & ~bypass_q & (^mem_read_data);
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_sram_1r1w_ctrl.sv
// Directed bench for sram_1r1w_ctrl with a behavioural 1R1W synchronous-read memory.
module tb_sram_1r1w_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned SZ    = 52;
  localparam int unsigned AW    = 6;
  localparam logic [DW-1:0] INIT_V = 32'h5A5A_0003;
`ifdef SRAM_CTRL_PARITY_EN
  localparam int unsigned MW = DW + 1;
  localparam logic [MW-1:0] INIT_W = {^INIT_V, INIT_V};
`else
  localparam int unsigned MW = DW;
  localparam logic [MW-1:0] INIT_W = INIT_V;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear;
  logic          init_done;
  logic          read_en;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          mem_read_en;
  logic [AW-1:0] mem_read_addr;
  logic [MW-1:0] mem_read_data;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_addr;
  logic [MW-1:0] mem_write_data;
  logic          parity_error;

  logic [MW-1:0] mem [64];
  logic [MW-1:0] mem_q;
  logic [MW-1:0] flip_mask;

  int n_vec = 0;
  int n_err = 0;
  int hits [64];
  int bad_wdata = 0;
  logic track = 1'b0;

  always #5 clk = ~clk;

  sram_1r1w_ctrl #(
    .DATA_WIDTH (DW),
    .SIZE       (SZ),
    .ADDR_WIDTH (AW),
    .INIT_VALUE (INIT_V)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (clear),
    .init_done      (init_done),
    .read_en        (read_en),
    .read_addr      (read_addr),
    .read_data      (read_data),
    .write_en       (write_en),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .mem_read_en    (mem_read_en),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .parity_error   (parity_error)
  );

  // Macro model: read-before-write on the same address, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
    if (mem_read_en)  mem_q <= mem[mem_read_addr];
  end
  assign mem_read_data = mem_q ^ flip_mask;

  // Sweep monitor.
  always @(posedge clk) begin
    if (reset_n && track && mem_write_en) begin
      hits[mem_write_addr] = hits[mem_write_addr] + 1;
      if (mem_write_data != INIT_W) bad_wdata = bad_wdata + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic re, input logic [AW-1:0] ra,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    read_en = re; read_addr = ra; write_en = we; write_addr = wa; write_data = wd;
    cycle();
    read_en = 1'b0; write_en = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      n++;
      if (init_done) break;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    reset_n = 1'b0; clear = 1'b0; flip_mask = '0;
    read_en = 1'b0; read_addr = '0; write_en = 1'b0; write_addr = '0; write_data = '0;
    repeat (3) cycle();

    // Reset state
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_read_data", read_data, 0);
    check_eq("rst_parity", parity_error, 0);
    check_eq("rst_mem_rd_en", mem_read_en, 0);

    // Initial sweep: exactly SZ cycles, every entry once, nothing beyond
    track = 1'b1;
    reset_n = 1'b1;
    wait_init(n);
    track = 1'b0;
    check_eq("init_cycles", n, SZ);
    bad = 0;
    for (int a = 0; a < 64; a++) if (hits[a] != ((a < SZ) ? 1 : 0)) bad++;
    check_eq("init_coverage", bad, 0);
    check_eq("init_wdata", bad_wdata, 0);
    check_eq("idle_no_write", mem_write_en, 0);

    // Basic write then read
    access(0, 0, 1, 5, 32'hDEAD_BEEF);
    access(1, 5, 0, 0, 0);
    check_eq("rd_after_wr", read_data, 32'hDEAD_BEEF);
    check_eq("rd_parity_clean", parity_error, 0);
    access(1, 6, 0, 0, 0);
    check_eq("rd_init_entry", read_data, INIT_V);

    // Read-during-write
    access(0, 0, 1, 9, 32'h11);
    access(1, 9, 1, 10, 32'h22);
    check_eq("rw_diff_addr", read_data, 32'h11);
    access(1, 9, 1, 9, 32'h22);
    check_eq("rw_same_addr", read_data, 32'h22);
    access(1, 10, 0, 0, 0);
    check_eq("rd_other_wr", read_data, 32'h22);
    read_en = 1'b1; read_addr = 9;
    cycle();
    read_en = 1'b0; write_en = 1'b1; write_addr = 9; write_data = 32'h55;
    check_eq("wr_after_rd_old", read_data, 32'h22);
    cycle();
    write_en = 1'b0;
    access(1, 9, 0, 0, 0);
    check_eq("wr_after_rd_new", read_data, 32'h55);

    // Hold and back-to-back reads
    access(0, 0, 1, 12, 32'h44);
    access(1, 12, 0, 0, 0);
    repeat (5) cycle();
    check_eq("hold_5_idle", read_data, 32'h44);
    for (int i = 0; i < 4; i++) access(0, 0, 1, AW'(20 + i), DW'(32'h100 + i));
    read_en = 1'b1; read_addr = 20;
    cycle();
    for (int i = 1; i < 4; i++) begin
      read_addr = AW'(20 + i);
      check_eq("b2b_rd", read_data, DW'(32'h100 + i - 1));
      cycle();
    end
    read_en = 1'b0;
    check_eq("b2b_rd_last", read_data, 32'h103);
    cycle();
    check_eq("b2b_hold", read_data, 32'h103);

    // Clear mid-run, client traffic during the sweep, clear mid-sweep
    access(0, 0, 1, 3, 32'h77);
    access(0, 0, 1, 40, 32'h4040_4040);
    pulse_clear();
    check_eq("clr_init_done", init_done, 0);
    repeat (9) cycle();
    access(0, 0, 1, 3, 32'h33);
    read_en = 1'b1; read_addr = 40;
    check_eq("init_rd_blocked", mem_read_en, 0);
    cycle();
    read_en = 1'b0;
    check_eq("init_rd_value", read_data, INIT_V);
    pulse_clear();
    wait_init(n);
    check_eq("clr_restart_cycles", n, SZ);
    access(1, 3, 0, 0, 0);
    check_eq("clr_entry3", read_data, INIT_V);
    access(1, 40, 0, 0, 0);
    check_eq("clr_entry40", read_data, INIT_V);

    // Reset asserted mid-sweep
    access(0, 0, 1, 3, 32'h33);
    pulse_clear();
    repeat (20) cycle();
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_init_done", init_done, 0);
    check_eq("midrst_read_data", read_data, 0);
    cycle();
    reset_n = 1'b1;
    wait_init(n);
    check_eq("midrst_cycles", n, SZ);
    access(1, 3, 0, 0, 0);
    check_eq("midrst_entry3", read_data, INIT_V);

`ifdef SRAM_CTRL_PARITY_EN
    access(0, 0, 1, 12, 32'h44);
    flip_mask = MW'(1) << 3;
    access(1, 12, 0, 0, 0);
    check_eq("par_err_pulse", parity_error, 1);
    check_eq("par_err_data", read_data, 32'h4C);
    cycle();
    check_eq("par_err_drop", parity_error, 0);
    access(1, 12, 1, 12, 32'h66);
    check_eq("par_bypass_none", parity_error, 0);
    check_eq("par_bypass_data", read_data, 32'h66);
    flip_mask = '0;
    access(1, 12, 0, 0, 0);
    check_eq("par_clean", parity_error, 0);
`else
    access(1, 12, 0, 0, 0);
    check_eq("nopar_tied", parity_error, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
